next_address_gen: RTL and testbench
===================================

NEXT_ADDRESS_GEN -- requirements
Module: next_address_gen

Interface
REQ-001 The block SHALL have parameter AW, default 8, meaning the address width in bits.
REQ-002 The block SHALL have parameter SD, default 4, meaning the return-stack depth in entries; legal values are 2 to 8.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, an asynchronous active-high reset.
REQ-005 The block SHALL have port stall, input, 1 bit: hold the current address this cycle.
REQ-006 The block SHALL have port branch, input, 1 bit: a conditional branch is taken this cycle.
REQ-007 The block SHALL have port offset, input, AW bits: two's-complement branch displacement.
REQ-008 The block SHALL have port jump, input, 1 bit: an absolute jump this cycle.
REQ-009 The block SHALL have port target, input, AW bits: the absolute jump/call destination.
REQ-010 The block SHALL have port call, input, 1 bit: push the return address and go to target.
REQ-011 The block SHALL have port ret, input, 1 bit: pop the return address and go to it.
REQ-012 The block SHALL have port halt, input, 1 bit: stop address generation.
REQ-013 The block SHALL have port nextaddress, output, AW bits: the registered address that feeds the PC stage.
REQ-014 The block SHALL have port fetch_valid, output, 1 bit: nextaddress is valid for fetch this cycle.
REQ-015 The block SHALL have port halted, output, 1 bit: the block is in state HALT.
REQ-016 The block SHALL have port stack_err, output, 1 bit: sticky flag for return-stack overflow or underflow.

Function
REQ-017 The state machine SHALL have three states: INIT, RUN and HALT.
REQ-018 INIT SHALL move to RUN unconditionally after one cycle; nextaddress stays 0 and fetch_valid stays 0 during INIT.
REQ-019 In RUN, fetch_valid SHALL be 1 and nextaddress SHALL update once per cycle using the priority order in REQ-020.
REQ-020 Update priority in RUN SHALL be: halt, then stall, then jump, then ret, then call, then branch, then sequential.
REQ-021 halt SHALL load nextaddress unchanged, move to HALT and set halted=1 and fetch_valid=0 from the next cycle.
REQ-022 stall SHALL hold nextaddress and the stack unchanged, and SHALL ignore all lower-priority requests that cycle.
REQ-023 jump SHALL load nextaddress with target.
REQ-024 ret SHALL pop the top stack entry into nextaddress; on an empty stack it SHALL instead load nextaddress+1 and set stack_err.
REQ-025 call SHALL push nextaddress+1 (mod 2^AW) and load target; on a full stack it SHALL still load target, discard the push and set stack_err.
REQ-026 branch SHALL load nextaddress+offset, truncated modulo 2^AW.
REQ-027 The sequential update SHALL load nextaddress+1, wrapping from 2^AW-1 to 0.
REQ-028 When call and ret are both asserted, ret SHALL win and the stack depth SHALL drop by exactly one.
REQ-029 HALT SHALL be exited only by rst; all inputs are ignored in HALT.
REQ-030 The stack SHALL be LIFO with an occupancy counter 0..SD; the stack contents are not observable except via ret.
REQ-031 The latency from any request input to the new nextaddress SHALL be exactly one clock.

Reset
REQ-032 Asserting rst SHALL immediately and asynchronously force: state=INIT, nextaddress=0, fetch_valid=0, halted=0, stack_err=0, stack occupancy=0.
REQ-033 rst asserted in the middle of any operation, including during a call or ret, SHALL abort it with no partial stack update.
REQ-034 The first valid address after rst deasserts SHALL be 0; it is presented in the second cycle, when the block enters RUN.

Verification
REQ-035 Sequential wrap: release rst, idle with AW=8 -> after INIT, nextaddress counts 0,1,2,…,255,0 with fetch_valid=1 throughout.
REQ-036 Branch: at nextaddress=0x10 drive branch=1 with offset=0xFC (-4) -> next cycle nextaddress=0x0C; stall=1 with branch=1 -> nextaddress holds.
REQ-037 Call/ret: at 0x20 drive call with target=0x80 -> 0x80; run 3 cycles -> 0x83; ret -> 0x21; stack_err=0.
REQ-038 Stack errors: ret on an empty stack at 0x05 -> 0x06 and stack_err=1; with SD=4, five nested calls -> fifth still jumps, stack_err=1.
REQ-039 Priority: jump, call and branch all asserted with target=0x40 -> 0x40 and no push; later halt=1 -> halted=1, fetch_valid=0, address frozen until rst.
REQ-040 Async reset: assert rst mid-cycle while nextaddress=0x37 -> outputs reach their reset values before the next clock edge; the sequence restarts at 0.

Source files
------------

// File: rtl/next_address_gen.sv
// Next-address generator for the fetch stage.
// Runs a three-state controller (INIT/RUN/HALT) and picks the next fetch
// address from halt, stall, jump, ret, call, branch or sequential increment,
// in that priority order, with a small LIFO return stack for call/ret.
module next_address_gen #(
    parameter int AW = 8,
    parameter int SD = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          branch,
    input  logic [AW-1:0] offset,
    input  logic          jump,
    input  logic [AW-1:0] target,
    input  logic          call,
    input  logic          ret,
    input  logic          halt,
    output logic [AW-1:0] nextaddress,
    output logic          fetch_valid,
    output logic          halted,
    output logic          stack_err
);

    // Occupancy needs to count 0..SD inclusive; entries are indexed 0..SD-1.
    localparam int SPW = $clog2(SD + 1);
    localparam int IW  = $clog2(SD);

    typedef enum logic [1:0] {
        INIT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t          state;
    state_t          state_n;
    logic [AW-1:0]   addr_n;
    logic [AW-1:0]   addr_inc;
    logic [SPW-1:0]  sp;
    logic [SPW-1:0]  sp_n;
    logic [SPW-1:0]  sp_dec;
    logic            err_n;
    logic            push;
    logic            stack_empty;
    logic            stack_full;
    logic [IW-1:0]   wr_idx;
    logic [IW-1:0]   rd_idx;
    logic [AW-1:0]   stack [SD];

    assign addr_inc    = nextaddress + AW'(1);
    assign sp_dec      = sp - SPW'(1);
    assign wr_idx      = sp[IW-1:0];
    assign rd_idx      = sp_dec[IW-1:0];
    assign stack_empty = (sp == '0);
    assign stack_full  = (sp == SPW'(SD));

    assign fetch_valid = (state == RUN);
    assign halted      = (state == HALT);

    // State, address, occupancy and sticky error register with async reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= INIT;
            nextaddress <= '0;
            sp          <= '0;
            stack_err   <= 1'b0;
        end else begin
            state       <= state_n;
            nextaddress <= addr_n;
            sp          <= sp_n;
            stack_err   <= err_n;
        end
    end

    // Stack storage is not reset: an occupancy of zero makes its contents dead.
    always_ff @(posedge clk) begin
        if (push) begin
            stack[wr_idx] <= addr_inc;
        end
    end

    // Next-state and next-address selection in priority order.
    always_comb begin
        state_n = state;
        addr_n  = nextaddress;
        sp_n    = sp;
        err_n   = stack_err;
        push    = 1'b0;
        case (state)
            INIT: begin
                state_n = RUN;
            end
            RUN: begin
                if (halt) begin
                    state_n = HALT;
                end else if (stall) begin
                    addr_n = nextaddress;
                end else if (jump) begin
                    addr_n = target;
                end else if (ret) begin
                    // ret outranks call, so call+ret is a plain pop.
                    if (stack_empty) begin
                        addr_n = addr_inc;
                        err_n  = 1'b1;
                    end else begin
                        addr_n = stack[rd_idx];
                        sp_n   = sp_dec;
                    end
                end else if (call) begin
                    // A call on a full stack still redirects; only the push is lost.
                    addr_n = target;
                    if (stack_full) begin
                        err_n = 1'b1;
                    end else begin
                        push = 1'b1;
                        sp_n = sp + SPW'(1);
                    end
                end else if (branch) begin
                    // Two's-complement offset: plain modular add gives the signed result.
                    addr_n = nextaddress + offset;
                end else begin
                    addr_n = addr_inc;
                end
            end
            HALT: begin
                state_n = HALT;
            end
            default: begin
                state_n = INIT;
            end
        endcase
    end

endmodule

// File: tb/tb_next_address_gen.sv
// Testbench for next_address_gen: directed scenarios plus a randomized run
// checked against a behavioural model built on a queue-based return stack.
module tb_next_address_gen;

    localparam int AW   = 8;
    localparam int SD   = 4;
    localparam int MASK = (1 << AW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          stall = 1'b0;
    logic          branch = 1'b0;
    logic [AW-1:0] offset = '0;
    logic          jump = 1'b0;
    logic [AW-1:0] target = '0;
    logic          call = 1'b0;
    logic          ret = 1'b0;
    logic          halt = 1'b0;
    logic [AW-1:0] nextaddress;
    logic          fetch_valid;
    logic          halted;
    logic          stack_err;

    int checks = 0;
    int errors = 0;

    // Reference model: 0 = INIT, 1 = RUN, 2 = HALT
    int m_state;
    int m_addr;
    int m_stack[$];
    bit m_err;

    next_address_gen #(.AW(AW), .SD(SD)) dut (
        .clk(clk), .rst(rst), .stall(stall), .branch(branch), .offset(offset),
        .jump(jump), .target(target), .call(call), .ret(ret), .halt(halt),
        .nextaddress(nextaddress), .fetch_valid(fetch_valid), .halted(halted),
        .stack_err(stack_err)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic model_reset();
        m_state = 0;
        m_addr  = 0;
        m_stack.delete();
        m_err   = 1'b0;
    endtask

    task automatic model_step();
        if (rst) begin
            model_reset();
        end else if (m_state == 0) begin
            m_state = 1;
        end else if (m_state == 1) begin
            if (halt) m_state = 2;
            else if (stall) ;
            else if (jump) m_addr = int'(target);
            else if (ret) begin
                if (m_stack.size() > 0) m_addr = m_stack.pop_back();
                else begin
                    m_addr = (m_addr + 1) & MASK;
                    m_err  = 1'b1;
                end
            end else if (call) begin
                if (m_stack.size() < SD) m_stack.push_back((m_addr + 1) & MASK);
                else m_err = 1'b1;
                m_addr = int'(target);
            end else if (branch) m_addr = (m_addr + int'(offset)) & MASK;
            else m_addr = (m_addr + 1) & MASK;
        end
    endtask

    task automatic clear_inputs();
        stall = 0; branch = 0; jump = 0; call = 0; ret = 0; halt = 0;
        offset = '0; target = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
    endtask

    task automatic goto_addr(input logic [AW-1:0] a);
        jump = 1'b1; target = a;
        tick();
        jump = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        #3 rst = 1'b1;
        model_reset();
        #1;
        checks++; if (nextaddress !== 8'h00) begin errors++; $display("FAIL reset_addr: got %h expected 00", nextaddress); end
        checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL reset_fv: got %b expected 0", fetch_valid); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b expected 0", halted); end
        checks++; if (stack_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", stack_err); end
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL init_fv: got %b expected 0", fetch_valid); end
        tick();
        checks++; if (nextaddress !== 8'h00 || fetch_valid !== 1'b1) begin errors++; $display("FAIL first_run: got addr=%h fv=%b expected 00/1", nextaddress, fetch_valid); end
    endtask

    task automatic test_seq_wrap();
        logic [AW-1:0] exp;
        do_reset();
        for (int i = 1; i <= 257; i++) begin
            tick();
            exp = AW'(i);
            checks++;
            if (nextaddress !== exp || fetch_valid !== 1'b1) begin
                errors++; $display("FAIL seq_wrap[%0d]: got addr=%h fv=%b expected %h/1", i, nextaddress, fetch_valid, exp);
            end
        end
    endtask

    task automatic test_branch();
        do_reset();
        goto_addr(8'h10);
        branch = 1'b1; offset = 8'hFC;
        tick();
        checks++; if (nextaddress !== 8'h0C) begin errors++; $display("FAIL branch_neg: got %h expected 0c", nextaddress); end
        stall = 1'b1;
        tick();
        checks++; if (nextaddress !== 8'h0C) begin errors++; $display("FAIL stall_branch: got %h expected 0c", nextaddress); end
        stall = 1'b0; offset = 8'h7F;
        tick();
        checks++; if (nextaddress !== 8'h8B) begin errors++; $display("FAIL branch_pos: got %h expected 8b", nextaddress); end
        branch = 1'b0;
    endtask

    task automatic test_call_ret();
        do_reset();
        goto_addr(8'h20);
        call = 1'b1; target = 8'h80;
        tick();
        call = 1'b0;
        checks++; if (nextaddress !== 8'h80) begin errors++; $display("FAIL call_target: got %h expected 80", nextaddress); end
        repeat (3) tick();
        checks++; if (nextaddress !== 8'h83) begin errors++; $display("FAIL call_run: got %h expected 83", nextaddress); end
        ret = 1'b1;
        tick();
        ret = 1'b0;
        checks++; if (nextaddress !== 8'h21 || stack_err !== 1'b0) begin errors++; $display("FAIL ret_addr: got %h err=%b expected 21/0", nextaddress, stack_err); end
        call = 1'b1; target = 8'h50; tick();
        target = 8'h60; tick();
        ret = 1'b1; tick();
        checks++; if (nextaddress !== 8'h51) begin errors++; $display("FAIL call_ret_both: got %h expected 51", nextaddress); end
        call = 1'b0; tick();
        checks++; if (nextaddress !== 8'h22 || stack_err !== 1'b0) begin errors++; $display("FAIL ret_second: got %h err=%b expected 22/0", nextaddress, stack_err); end
        tick();
        checks++; if (nextaddress !== 8'h23 || stack_err !== 1'b1) begin errors++; $display("FAIL ret_underflow: got %h err=%b expected 23/1", nextaddress, stack_err); end
        ret = 1'b0;
    endtask

    task automatic test_stack_err();
        logic [AW-1:0] exp;
        do_reset();
        goto_addr(8'h05);
        ret = 1'b1; tick(); ret = 1'b0;
        checks++; if (nextaddress !== 8'h06 || stack_err !== 1'b1) begin errors++; $display("FAIL ret_empty: got %h err=%b expected 06/1", nextaddress, stack_err); end
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            call = 1'b1; target = AW'(i * 16);
            tick();
            exp = AW'(i * 16);
            checks++;
            if (nextaddress !== exp || stack_err !== (i == 5)) begin
                errors++; $display("FAIL nested_call[%0d]: got %h err=%b expected %h/%b", i, nextaddress, stack_err, exp, (i == 5));
            end
        end
        call = 1'b0; ret = 1'b1;
        for (int i = 4; i >= 1; i--) begin
            tick();
            exp = (i == 1) ? 8'h01 : AW'((i - 1) * 16 + 1);
            checks++;
            if (nextaddress !== exp) begin errors++; $display("FAIL lifo_pop[%0d]: got %h expected %h", i, nextaddress, exp); end
        end
        ret = 1'b0;
    endtask

    task automatic test_priority_halt();
        do_reset();
        jump = 1'b1; call = 1'b1; branch = 1'b1; target = 8'h40; offset = 8'h03;
        tick();
        clear_inputs();
        checks++; if (nextaddress !== 8'h40) begin errors++; $display("FAIL prio_jump: got %h expected 40", nextaddress); end
        ret = 1'b1; tick(); ret = 1'b0;
        checks++; if (nextaddress !== 8'h41 || stack_err !== 1'b1) begin errors++; $display("FAIL prio_no_push: got %h err=%b expected 41/1", nextaddress, stack_err); end
        halt = 1'b1; jump = 1'b1; target = 8'h99; tick();
        checks++; if (halted !== 1'b1 || fetch_valid !== 1'b0 || nextaddress !== 8'h41) begin errors++; $display("FAIL halt_enter: got h=%b fv=%b addr=%h expected 1/0/41", halted, fetch_valid, nextaddress); end
        halt = 1'b0;
        for (int i = 0; i < 6; i++) begin
            jump = 1'($urandom); call = 1'($urandom); ret = 1'($urandom); branch = 1'($urandom);
            target = AW'($urandom); offset = AW'($urandom);
            tick();
            checks++;
            if (halted !== 1'b1 || fetch_valid !== 1'b0 || nextaddress !== 8'h41) begin
                errors++; $display("FAIL halt_frozen[%0d]: got h=%b fv=%b addr=%h expected 1/0/41", i, halted, fetch_valid, nextaddress);
            end
        end
        do_reset();
        checks++; if (halted !== 1'b0 || nextaddress !== 8'h00 || fetch_valid !== 1'b1) begin errors++; $display("FAIL halt_exit: got h=%b addr=%h fv=%b expected 0/00/1", halted, nextaddress, fetch_valid); end
    endtask

    task automatic test_async_reset();
        do_reset();
        goto_addr(8'h30);
        call = 1'b1; target = 8'h37; tick(); call = 1'b0;
        checks++; if (nextaddress !== 8'h37) begin errors++; $display("FAIL pre_reset: got %h expected 37", nextaddress); end
        ret = 1'b1;
        #3 rst = 1'b1;
        model_reset();
        #1;
        checks++; if (nextaddress !== 8'h00 || fetch_valid !== 1'b0 || halted !== 1'b0 || stack_err !== 1'b0) begin
            errors++; $display("FAIL async_reset: got addr=%h fv=%b h=%b err=%b expected 00/0/0/0", nextaddress, fetch_valid, halted, stack_err);
        end
        ret = 1'b0;
        #2 rst = 1'b0;
        tick();
        checks++; if (nextaddress !== 8'h00 || fetch_valid !== 1'b1) begin errors++; $display("FAIL restart0: got %h fv=%b expected 00/1", nextaddress, fetch_valid); end
        tick();
        checks++; if (nextaddress !== 8'h01) begin errors++; $display("FAIL restart1: got %h expected 01", nextaddress); end
        ret = 1'b1; tick(); ret = 1'b0;
        checks++; if (nextaddress !== 8'h02 || stack_err !== 1'b1) begin errors++; $display("FAIL stack_cleared: got %h err=%b expected 02/1", nextaddress, stack_err); end
    endtask

    task automatic test_random();
        int halt_cycles;
        logic [AW-1:0] exp_addr;
        do_reset();
        halt_cycles = 0;
        for (int i = 0; i < 3000; i++) begin
            if (m_state == 2) halt_cycles++;
            if (halt_cycles > 4) begin
                do_reset();
                halt_cycles = 0;
            end
            stall  = ($urandom % 8) == 0;
            branch = ($urandom % 3) == 0;
            jump   = ($urandom % 8) == 0;
            call   = ($urandom % 4) == 0;
            ret    = ($urandom % 4) == 0;
            halt   = ($urandom % 300) == 0;
            offset = AW'($urandom);
            target = AW'($urandom);
            tick();
            exp_addr = AW'(m_addr);
            checks++;
            if (nextaddress !== exp_addr || fetch_valid !== (m_state == 1) ||
                halted !== (m_state == 2) || stack_err !== m_err) begin
                errors++;
                $display("FAIL random[%0d]: got addr=%h fv=%b h=%b err=%b expected %h/%b/%b/%b",
                         i, nextaddress, fetch_valid, halted, stack_err,
                         exp_addr, (m_state == 1), (m_state == 2), m_err);
            end
        end
        clear_inputs();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_seq_wrap();
        test_branch();
        test_call_ret();
        test_stack_err();
        test_priority_halt();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
